data_memory: RTL and testbench

- Word-organised data memory for the KGPMini RISC datapath, sitting in the MEM stage between the ALU (address source) and the write-back mux.
- Stores are synchronous (rising clk, MemWrite).
- Loads are asynchronous/combinational, gated by MemRead.
- Asynchronous active-low reset clears the whole array.

---
 rtl/data_memory.sv | 34 +++
 tb/tb_data_memory.sv | 109 ++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: word-addressed data memory with synchronous writes, combinational gated reads and an async clear.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] a_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic                  clk,
  input  logic                  rst,
  output logic                  addr_err
);
  localparam int INDEX_BITS = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  in_range;
  logic [INDEX_BITS-1:0] idx;
  logic                  wr_en;
  always_comb begin
    in_range = (a_in >> INDEX_BITS) == '0;
    idx      = a_in[INDEX_BITS-1:0];
    wr_en    = rst & MemWrite & in_range;
    data_out = (rst & MemRead & in_range) ? mem_q[idx] : '0;
    addr_err = rst & ~in_range & (MemRead | MemWrite);
  end
  // an X on MemWrite makes wr_en X, which the if treats as false, so nothing is stored
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    else if (wr_en)
      mem_q[idx] <= data;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: table-driven directed vectors plus hand sequences for reset and same-cycle read/write.
module tb_data_memory;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_in, data, data_out;
  logic        mem_write, mem_read, addr_err;
  int          total = 0;
  int          bad = 0;
  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    logic        err;
  } vec_t;
  vec_t vt[$];
  data_memory dut (
    .a_in(a_in), .data_out(data_out), .data(data), .MemWrite(mem_write),
    .MemRead(mem_read), .clk(clk), .rst(rst), .addr_err(addr_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    mem_write = we;
    mem_read  = re;
    a_in      = a;
    data      = d;
  endtask
  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'd0, 32'd0);
    #2;
    check("reset_out", data_out, 32'd0);
    check("reset_err", {31'd0, addr_err}, 32'd0);
    #5 rst = 1'b1;
    vt.push_back('{1'b0, 1'b0, 32'd1,          32'd69,         32'd0,          1'b0});
    vt.push_back('{1'b1, 1'b0, 32'd1,          32'd69,         32'd0,          1'b0});
    vt.push_back('{1'b0, 1'b1, 32'd1,          32'd0,          32'd69,         1'b0});
    vt.push_back('{1'b0, 1'b0, 32'd1,          32'd0,          32'd0,          1'b0});
    vt.push_back('{1'b1, 1'b0, 32'd0,          32'hDEADBEEF,   32'd0,          1'b0});
    vt.push_back('{1'b1, 1'b0, 32'd1023,       32'h12345678,   32'd0,          1'b0});
    vt.push_back('{1'b0, 1'b1, 32'd0,          32'd0,          32'hDEADBEEF,   1'b0});
    vt.push_back('{1'b0, 1'b1, 32'd1023,       32'd0,          32'h12345678,   1'b0});
    vt.push_back('{1'b0, 1'b1, 32'd512,        32'd0,          32'd0,          1'b0});
    vt.push_back('{1'b0, 1'b1, 32'd1,          32'd0,          32'd69,         1'b0});
    vt.push_back('{1'b1, 1'b0, 32'd1024,       32'd5,          32'd0,          1'b1});
    vt.push_back('{1'b0, 1'b1, 32'd0,          32'd0,          32'hDEADBEEF,   1'b0});
    vt.push_back('{1'b0, 1'b1, 32'd1024,       32'd0,          32'd0,          1'b1});
    vt.push_back('{1'b1, 1'b0, 32'h8000_0001,  32'd7,          32'd0,          1'b1});
    vt.push_back('{1'b0, 1'b1, 32'd1,          32'd0,          32'd69,         1'b0});
    vt.push_back('{1'b0, 1'b1, 32'hFFFF_FFFF,  32'd0,          32'd0,          1'b1});
    vt.push_back('{1'b0, 1'b0, 32'd2000,       32'd0,          32'd0,          1'b0});
    vt.push_back('{1'b1, 1'b0, 32'd7,          32'd3,          32'd0,          1'b0});
    vt.push_back('{1'b0, 1'b1, 32'd7,          32'd0,          32'd3,          1'b0});
    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].we, vt[i].re, vt[i].a, vt[i].d);
      #1;
      check($sformatf("vec%0d_out", i), data_out, vt[i].exp);
      check($sformatf("vec%0d_err", i), {31'd0, addr_err}, {31'd0, vt[i].err});
    end
    @(negedge clk);
    drive(1'b1, 1'b1, 32'd7, 32'd9);
    #1 check("rw_before_edge", data_out, 32'd3);
    @(posedge clk);
    #1 check("rw_after_edge", data_out, 32'd9);
    @(negedge clk);
    drive(1'bx, 1'b0, 32'd7, 32'd55);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'd7, 32'd0);
    #1 check("x_write_blocked", data_out, 32'd9);
    drive(1'b0, 1'b1, 32'd0, 32'd0);
    #1 check("pre_reset_read", data_out, 32'hDEADBEEF);
    rst = 1'b0;
    #1 check("async_reset_out", data_out, 32'd0);
    drive(1'b1, 1'b1, 32'd1024, 32'd5);
    #1 check("reset_err_low", {31'd0, addr_err}, 32'd0);
    drive(1'b1, 1'b0, 32'd3, 32'd77);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    drive(1'b0, 1'b1, 32'd3, 32'd0);
    #1 check("write_during_reset", data_out, 32'd0);
    a_in = 32'd0;
    #1 check("cleared_0", data_out, 32'd0);
    a_in = 32'd1;
    #1 check("cleared_1", data_out, 32'd0);
    a_in = 32'd1023;
    #1 check("cleared_1023", data_out, 32'd0);
    a_in = 32'd7;
    #1 check("cleared_7", data_out, 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'd3, 32'd11);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'd3, 32'd0);
    #1 check("first_write_after_release", data_out, 32'd11);
    mem_read = 1'b0;
    #1 check("read_disabled", data_out, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
